toy_program_loader: RTL and testbench
=====================================

# toy_program_loader

Writer side of the toy processor's 256-byte instruction memory. It accepts one symbolic instruction per handshake and encodes it into the 32-bit toy-MIPS word format. It then writes the word big-endian, one byte per cycle, into the memory's byte write port. It holds the core in reset until the last instruction is written, then releases it.

## Interface
- `ADDR_W`, default 8: instruction-memory byte address width.
- `MAX_WORDS`, default 64: capacity in words (2^ADDR_W / 4).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: loader can accept.
- `in_op` in 4: operation. NOP=0, ADD=1, SUB=2, SLL=3, SRL=4, MOVE=5, LI=6, ADDI=7, LW=8, SW=9, BGE=10, BLE=11, J=12; 13–15 illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_imm` in 16: immediate, offset, or branch/jump target.
- `in_last` in 1: final instruction of the program.
- `mem_we` out 1: byte write strobe.
- `mem_addr` out ADDR_W: byte address.
- `mem_wdata` out 8: byte data.
- `word_count` out 7: words fully written.
- `cpu_reset` out 1: core reset request.
- `done` out 1: load complete (sticky).
- `err` out 1: illegal op or overflow (sticky).

## Operation
- Encoding, I-type (LI 001001, ADDI 001000, LW 100011, SW 101011, BGE 000111, BLE 000110): {opcode, rs, rt, imm}. LI forces rs=0.
- Branch targets: the core uses instr[7:0] as the target, so the encoder places the target in imm[7:0]. Only imm[7:0] is meaningful for BGE/BLE.
- J: {000010, 18'b0, imm[7:0]}.
- R-type: {000000, rs, rt, rd, shamt, funct}.
  - funct values: ADD 100000, SUB 100010, SLL 000000, SRL 000010, MOVE 100001.
  - SLL/SRL force rs=0. MOVE forces rt=0 and shamt=0. ADD/SUB force shamt=0.
  - NOP = 32'h0.
- States: IDLE, WRITE (byte index 0–3), DONE, ERR.
  - IDLE: `in_ready`=1.
  - IDLE, accept with a legal op and word_count<MAX_WORDS: latch the encoded word and `in_last`, go to WRITE.
  - IDLE, accept with an illegal op: go to ERR.
  - IDLE, accept with word_count==MAX_WORDS: go to ERR.
  - WRITE: emit bytes [31:24], [23:16], [15:8], [7:0] to base, base+1, base+2, base+3, where base = 4·word_count.
  - After byte 3: word_count increments. Go to DONE if the latched last flag is set, else IDLE.
  - DONE and ERR are absorbing until `reset`. `in_ready`=0 in both. No writes occur in ERR.
- `cpu_reset`=1 in every state except DONE.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after reset. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `word_count`=0, `cpu_reset`=1, `done`=0, `err`=0.
- Accept at edge T (in_valid & in_ready): `mem_we`=1 in cycles T+1..T+4, addresses ascending. `in_ready`=0 during T+1..T+4, and 1 again at T+5 if not last.
- Sustained throughput: one word per 5 cycles.
- `word_count` updates in the same cycle as byte 3 leaves WRITE. It is visible at T+5.
- Last word: `done`=1 and `cpu_reset`=0 from T+5.
- Illegal or overflow accept at T: `err`=1 from T+1, and `mem_we` never asserts.
- `in_valid` without `in_ready` is ignored. Fields are sampled only on accept.
- Reset mid-WRITE: the write aborts with `mem_we`=0 the next cycle, and all outputs return to reset values. Partial bytes already in memory are not cleared. The next word goes to address 0.
- Address arithmetic is ADDR_W bits. Wrap-around cannot occur because overflow is rejected first.

## Structure
- Package `toy_isa_pkg`: opcode and funct localparams, the `in_op` enum, and the FSM state typedef. The core will later import the same constants.
- Sub-module `toy_instr_encoder`: combinational; maps op fields to a 32-bit word plus an illegal flag.
- Top level: handshake, FSM, byte sequencing, counters.

## Test plan
- LI rt=8, imm=5 at T: word 0x24080005. Bytes 24, 08, 00, 05 at addr 0–3 in T+1..T+4. `word_count`=1 at T+5.
- ADD rs=8, rt=9, rd=10, then SLL rt=3, rd=2, shamt=4, with `in_valid` held high:
  - Words 0x01095020 at addr 0–3 and 0x00031100 at addr 4–7.
  - `in_ready` low for 4 cycles between accepts.
- J imm=0x10 with `in_last`=1 as the third word: 08 00 00 10 written at addr 8–11. `done`=1 and `cpu_reset`=0 from T+5. Later `in_valid` pulses cause no writes.
- `in_op`=13: `err`=1 next cycle, `mem_we` stays 0, `in_ready` stays 0, `cpu_reset` stays 1 until `reset`.
- 64 legal words, then a 65th: the last write goes to addr 252–255, then `err`=1 and no write to address 0.
- `reset` asserted at T+2 of a word: `mem_we`=0 at T+3, `word_count`=0. The next accepted word writes from addr 0.

Source files
------------

// File: rtl/toy_program_loader_pkg.sv
// rtl/toy_program_loader_pkg.sv - toy ISA constants shared by the loader and the core
// Purpose: opcode/funct encodings, the symbolic operation enum and the loader FSM state type.
// Ports: none (package toy_isa_pkg).
package toy_isa_pkg;

    // Primary opcode field, instr[31:26]
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BLE   = 6'b000110;
    localparam logic [5:0] OPC_BGE   = 6'b000111;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LI    = 6'b001001;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // R-type function field, instr[5:0]
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_MOVE = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;

    // Symbolic operation presented on the loader input; 13..15 are illegal
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SLL  = 4'd3,
        OP_SRL  = 4'd4,
        OP_MOVE = 4'd5,
        OP_LI   = 4'd6,
        OP_ADDI = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_BGE  = 4'd10,
        OP_BLE  = 4'd11,
        OP_J    = 4'd12
    } toy_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/toy_program_loader_if.sv
// rtl/toy_program_loader_if.sv - instruction handshake and memory byte-write interfaces
// Purpose: toy_instr_if carries one symbolic instruction per valid/ready handshake;
//          toy_mem_if carries the byte write port into instruction memory.
// Ports: master drives the transfer, slave receives it (in_ready flows slave->master).
interface toy_instr_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        output in_ready
    );
endinterface

interface toy_mem_if #(
    parameter int ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/toy_program_loader_encoder.sv
// rtl/toy_program_loader_encoder.sv - combinational symbolic-to-binary instruction encoder
// Purpose: maps op fields onto a 32-bit toy-MIPS word and flags unknown ops.
// Ports: i_op/i_rs/i_rt/i_rd/i_shamt/i_imm in; o_word encoded word, o_illegal for ops 13..15.
module toy_instr_encoder
    import toy_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_op)
            OP_NOP:  o_word = 32'h0;
            OP_ADD:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FUNCT_ADD};
            OP_SUB:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FUNCT_SUB};
            OP_SLL:  o_word = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL};
            OP_SRL:  o_word = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SRL};
            OP_MOVE: o_word = {OPC_RTYPE, i_rs, 5'd0, i_rd, 5'd0, FUNCT_MOVE};
            OP_LI:   o_word = {OPC_LI, 5'd0, i_rt, i_imm};
            OP_ADDI: o_word = {OPC_ADDI, i_rs, i_rt, i_imm};
            OP_LW:   o_word = {OPC_LW, i_rs, i_rt, i_imm};
            OP_SW:   o_word = {OPC_SW, i_rs, i_rt, i_imm};
            // The core fetches branch targets from instr[7:0]; upper imm bits are cleared
            OP_BGE:  o_word = {OPC_BGE, i_rs, i_rt, 8'h00, i_imm[7:0]};
            OP_BLE:  o_word = {OPC_BLE, i_rs, i_rt, 8'h00, i_imm[7:0]};
            OP_J:    o_word = {OPC_J, 18'd0, i_imm[7:0]};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/toy_program_loader.sv
// rtl/toy_program_loader.sv - writes an encoded toy program into instruction memory
// Purpose: accepts symbolic instructions, encodes them, writes each word big-endian one
//          byte per cycle, and holds the core in reset until the last word is written.
// Ports: clk, reset (sync, active-high); instr (slave handshake); mem (byte write master);
//        word_count words written, cpu_reset core reset request, done/err sticky status.
module toy_program_loader
    import toy_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    toy_instr_if.slave        instr,
    toy_mem_if.master         mem,
    output logic [6:0]        word_count,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [6:0]        MAX_WC   = 7'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    loader_state_e     r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [6:0]        r_word_count;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_word;
    logic              r_last;
    // Index of the next byte to emit; reaching 4 means byte 3 is on the bus this cycle
    logic [2:0]        r_idx;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic [ADDR_W-1:0] w_base;
    logic [7:0]        w_next_byte;
    logic              w_accept;

    toy_instr_encoder u_encoder (
        .i_op      (instr.in_op),
        .i_rs      (instr.in_rs),
        .i_rt      (instr.in_rt),
        .i_rd      (instr.in_rd),
        .i_shamt   (instr.in_shamt),
        .i_imm     (instr.in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_base   = {r_word_count[ADDR_W-3:0], 2'b00};
    assign w_accept = r_in_ready & instr.in_valid;

    always_comb begin
        w_next_byte = r_word[31:24];
        case (r_idx[1:0])
            2'd1:    w_next_byte = r_word[23:16];
            2'd2:    w_next_byte = r_word[15:8];
            2'd3:    w_next_byte = r_word[7:0];
            default: w_next_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_word_count <= 7'd0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word       <= 32'h0;
            r_last       <= 1'b0;
            r_idx        <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_illegal || (r_word_count == MAX_WC)) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            // Byte 0 goes out straight from the encoder so the first
                            // write lands in the cycle right after the accept
                            r_state     <= ST_WRITE;
                            r_word      <= w_word;
                            r_last      <= instr.in_last;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_base;
                            r_mem_wdata <= w_word[31:24];
                            r_idx       <= 3'd1;
                        end
                    end else begin
                        // Covers the first cycle out of reset
                        r_in_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_idx == 3'd4) begin
                        r_mem_we     <= 1'b0;
                        r_idx        <= 3'd0;
                        r_word_count <= r_word_count + 7'd1;
                        if (r_last) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_mem_addr  <= r_mem_addr + ADDR_ONE;
                        r_mem_wdata <= w_next_byte;
                        r_idx       <= r_idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_in_ready <= 1'b0;
                end
                ST_ERR: begin
                    r_in_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign instr.in_ready = r_in_ready;
    assign mem.mem_we     = r_mem_we;
    assign mem.mem_addr   = r_mem_addr;
    assign mem.mem_wdata  = r_mem_wdata;
    assign word_count     = r_word_count;
    assign cpu_reset      = r_cpu_reset;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_toy_program_loader.sv
// tb/tb_toy_program_loader.sv - directed self-checking bench for toy_program_loader
module tb_toy_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] word_count;
    logic       cpu_reset;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_count = 0;
    logic [7:0] mem_model [256];

    toy_instr_if iif ();
    toy_mem_if #(.ADDR_W(8)) mif ();

    toy_program_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (iif.slave),
        .mem        (mif.master),
        .word_count (word_count),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Instruction memory model: byte write port sampled on the clock edge
    always @(posedge clk) begin
        if (mif.mem_we) begin
            mem_model[mif.mem_addr] <= mif.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    function automatic logic [31:0] model_word(input int base);
        return {mem_model[base], mem_model[base+1], mem_model[base+2], mem_model[base+3]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        iif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Presents one instruction and waits for the accept edge T; returns at the negedge of T+1
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic last, input bit hold);
        bit ok;
        ok = 1'b0;
        iif.in_op = op; iif.in_rs = rs; iif.in_rt = rt; iif.in_rd = rd;
        iif.in_shamt = sh; iif.in_imm = imm; iif.in_last = last;
        iif.in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (iif.in_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout op=%0d got no in_ready exp in_ready within 40 cycles", op);
        end
        @(negedge clk);
        if (!hold) iif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", iif.in_ready); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", mif.mem_we); end
        n_cmp++; if (mif.mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %h exp 00", mif.mem_addr); end
        n_cmp++; if (mif.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h exp 00", mif.mem_wdata); end
        n_cmp++; if (word_count !== 7'd0) begin n_fail++; $display("FAIL rst_wc got %0d exp 0", word_count); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (iif.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", iif.in_ready); end
    endtask

    task automatic test_li();
        logic [31:0] w;
        w = 32'h24080005;
        send(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL li_we k=%0d got %b exp 1", k, mif.mem_we); end
            n_cmp++; if (mif.mem_addr !== 8'(k)) begin n_fail++; $display("FAIL li_addr k=%0d got %h exp %h", k, mif.mem_addr, 8'(k)); end
            n_cmp++; if (mif.mem_wdata !== w[31-8*k -: 8]) begin n_fail++; $display("FAIL li_byte k=%0d got %h exp %h", k, mif.mem_wdata, w[31-8*k -: 8]); end
            n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL li_ready_busy k=%0d got %b exp 0", k, iif.in_ready); end
            @(negedge clk);
        end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL li_we_end got %b exp 0", mif.mem_we); end
        n_cmp++; if (word_count !== 7'd1) begin n_fail++; $display("FAIL li_wc got %0d exp 1", word_count); end
        n_cmp++; if (iif.in_ready !== 1'b1) begin n_fail++; $display("FAIL li_ready_end got %b exp 1", iif.in_ready); end
        n_cmp++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL li_status got cpu_reset=%b done=%b exp 1/0", cpu_reset, done); end
        n_cmp++; if (model_word(0) !== w) begin n_fail++; $display("FAIL li_mem got %h exp %h", model_word(0), w); end
    endtask

    task automatic test_back_to_back();
        int wr0;
        do_reset();
        send(4'd1, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0000, 1'b0, 1'b1);
        // in_valid stays high while the SLL fields are presented
        iif.in_op = 4'd3; iif.in_rs = 5'd0; iif.in_rt = 5'd3; iif.in_rd = 5'd2; iif.in_shamt = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low k=%0d got %b exp 0", k, iif.in_ready); end
            n_cmp++; if (mif.mem_addr !== 8'(k-1)) begin n_fail++; $display("FAIL b2b_addr k=%0d got %h exp %h", k, mif.mem_addr, 8'(k-1)); end
            @(negedge clk);
        end
        n_cmp++; if (iif.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_t5 got %b exp 1", iif.in_ready); end
        send(4'd3, 5'd0, 5'd3, 5'd2, 5'd4, 16'h0000, 1'b0, 1'b0);
        n_cmp++; if (mif.mem_addr !== 8'd4 || mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_sll_start got addr=%h we=%b exp 04/1", mif.mem_addr, mif.mem_we); end
        repeat (4) @(negedge clk);
        n_cmp++; if (word_count !== 7'd2) begin n_fail++; $display("FAIL b2b_wc got %0d exp 2", word_count); end
        n_cmp++; if (model_word(0) !== 32'h01095020) begin n_fail++; $display("FAIL b2b_add got %h exp 01095020", model_word(0)); end
        n_cmp++; if (model_word(4) !== 32'h00031100) begin n_fail++; $display("FAIL b2b_sll got %h exp 00031100", model_word(4)); end

        send(4'd12, 5'd5, 5'd6, 5'd7, 5'd1, 16'hFF10, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL j_early k=%0d got done=%b cpu_reset=%b exp 0/1", k, done, cpu_reset); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL j_done got %b exp 1", done); end
        n_cmp++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL j_cpu_reset got %b exp 0", cpu_reset); end
        n_cmp++; if (word_count !== 7'd3) begin n_fail++; $display("FAIL j_wc got %0d exp 3", word_count); end
        n_cmp++; if (model_word(8) !== 32'h08000010) begin n_fail++; $display("FAIL j_word got %h exp 08000010", model_word(8)); end
        wr0 = wr_count;
        for (int k = 0; k < 4; k++) begin
            iif.in_valid = 1'b1;
            n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready k=%0d got %b exp 0", k, iif.in_ready); end
            @(negedge clk);
            iif.in_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (wr_count !== wr0) begin n_fail++; $display("FAIL done_writes got %0d exp %0d", wr_count, wr0); end
        n_cmp++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL done_sticky got done=%b cpu_reset=%b exp 1/0", done, cpu_reset); end
    endtask

    task automatic test_illegal();
        int wr0;
        do_reset();
        wr0 = wr_count;
        send(4'd13, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 1'b0, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got %b exp 1", err); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL ill_we got %b exp 0", mif.mem_we); end
        for (int k = 0; k < 6; k++) begin
            iif.in_valid = k[0];
            @(negedge clk);
        end
        iif.in_valid = 1'b0;
        n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL ill_ready got %b exp 0", iif.in_ready); end
        n_cmp++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ill_status got cpu_reset=%b done=%b exp 1/0", cpu_reset, done); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky got %b exp 1", err); end
        n_cmp++; if (wr_count !== wr0) begin n_fail++; $display("FAIL ill_writes got %0d exp %0d", wr_count, wr0); end
    endtask

    task automatic test_encodings();
        logic [3:0]  ops [11] = '{4'd5, 4'd4, 4'd10, 4'd8, 4'd9, 4'd11, 4'd0, 4'd1, 4'd6, 4'd2, 4'd7};
        logic [4:0]  rss [11] = '{5'd4, 5'd9, 5'd1, 5'd29, 5'd29, 5'd1, 5'd3, 5'd8, 5'd3, 5'd1, 5'd1};
        logic [4:0]  rts [11] = '{5'd7, 5'd3, 5'd2, 5'd4, 5'd4, 5'd2, 5'd3, 5'd9, 5'd8, 5'd2, 5'd2};
        logic [4:0]  rds [11] = '{5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd10, 5'd0, 5'd3, 5'd0};
        logic [4:0]  shs [11] = '{5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd5, 5'd0, 5'd0, 5'd0};
        logic [15:0] ims [11] = '{16'h0, 16'h0, 16'hAB12, 16'h0008, 16'h0008, 16'h0034,
                                  16'hFFFF, 16'h0, 16'h0005, 16'h0, 16'h1234};
        logic [31:0] exp [11] = '{32'h00802821, 32'h00031042, 32'h1C220012, 32'h8FA40008,
                                  32'hAFA40008, 32'h18220034, 32'h00000000, 32'h01095020,
                                  32'h24080005, 32'h00221822, 32'h20221234};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send(ops[i], rss[i], rts[i], rds[i], shs[i], ims[i], 1'b0, 1'b0);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (word_count !== 7'd11) begin n_fail++; $display("FAIL enc_wc got %0d exp 11", word_count); end
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (model_word(4*i) !== exp[i]) begin n_fail++; $display("FAIL enc_word op=%0d got %h exp %h", ops[i], model_word(4*i), exp[i]); end
        end
    endtask

    task automatic test_overflow();
        int wr0;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 1'b0, 1'b0);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (word_count !== 7'd64) begin n_fail++; $display("FAIL ovf_wc got %0d exp 64", word_count); end
        n_cmp++; if (model_word(252) !== 32'h2022003F) begin n_fail++; $display("FAIL ovf_last_word got %h exp 2022003f", model_word(252)); end
        n_cmp++; if (model_word(0) !== 32'h20220000) begin n_fail++; $display("FAIL ovf_first_word got %h exp 20220000", model_word(0)); end
        n_cmp++; if (iif.in_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_full got %b exp 1", iif.in_ready); end
        wr0 = wr_count;
        send(4'd6, 5'd0, 5'd9, 5'd0, 5'd0, 16'hFFFF, 1'b0, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", err); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we got %b exp 0", mif.mem_we); end
        repeat (5) @(negedge clk);
        n_cmp++; if (wr_count !== wr0) begin n_fail++; $display("FAIL ovf_writes got %0d exp %0d", wr_count, wr0); end
        n_cmp++; if (mem_model[0] !== 8'h20) begin n_fail++; $display("FAIL ovf_addr0 got %h exp 20", mem_model[0]); end
        n_cmp++; if (iif.in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got %b exp 0", iif.in_ready); end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        send(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0, 1'b0);
        n_cmp++; if (mif.mem_we !== 1'b1 || mif.mem_addr !== 8'd0) begin n_fail++; $display("FAIL mid_t1 got we=%b addr=%h exp 1/00", mif.mem_we, mif.mem_addr); end
        @(negedge clk);
        n_cmp++; if (mif.mem_we !== 1'b1 || mif.mem_addr !== 8'd1) begin n_fail++; $display("FAIL mid_t2 got we=%b addr=%h exp 1/01", mif.mem_we, mif.mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we got %b exp 0", mif.mem_we); end
        n_cmp++; if (word_count !== 7'd0 || mif.mem_addr !== 8'd0) begin n_fail++; $display("FAIL mid_wc got wc=%0d addr=%h exp 0/00", word_count, mif.mem_addr); end
        n_cmp++; if (iif.in_ready !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_status got ready=%b cpu_reset=%b exp 0/1", iif.in_ready, cpu_reset); end
        reset = 1'b0;
        @(negedge clk);
        send(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b0, 1'b0);
        n_cmp++; if (mif.mem_addr !== 8'd0 || mif.mem_wdata !== 8'h24) begin n_fail++; $display("FAIL mid_restart got addr=%h data=%h exp 00/24", mif.mem_addr, mif.mem_wdata); end
        repeat (4) @(negedge clk);
        n_cmp++; if (model_word(0) !== 32'h24080005) begin n_fail++; $display("FAIL mid_word got %h exp 24080005", model_word(0)); end
        n_cmp++; if (word_count !== 7'd1) begin n_fail++; $display("FAIL mid_wc_after got %0d exp 1", word_count); end
    endtask

    initial begin
        iif.in_valid = 1'b0; iif.in_op = 4'd0; iif.in_rs = 5'd0; iif.in_rt = 5'd0;
        iif.in_rd = 5'd0; iif.in_shamt = 5'd0; iif.in_imm = 16'h0; iif.in_last = 1'b0;
        test_reset();
        test_li();
        test_back_to_back();
        test_illegal();
        test_encodings();
        test_overflow();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
